// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master sequencer.
// Holds the sequencer state encoding, the quarter-bit phase encoding and the
// constants used for the transaction direction bit.
package i2c_pkg;

   // Sequencer states. The S_ prefix keeps them from colliding with the
   // START / ADDR port names of the top module.
   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_ADDR,
      S_ADDR_ACK,
      S_WR_BYTE,
      S_WR_ACK,
      S_RD_BYTE,
      S_RD_ACK,
      S_STOP
   } state_e;

   // Each bit on the bus is split into four equal quarters.
   // SCL is low in Q0 and Q3 and high in Q1 and Q2.
   typedef enum logic [1:0] {
      PH_Q0 = 2'd0,
      PH_Q1 = 2'd1,
      PH_Q2 = 2'd2,
      PH_Q3 = 2'd3
   } phase_e;

   // Value of the R/W bit that follows the 7-bit slave address.
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_qdiv.sv
// Quarter-bit timing generator for the I2C master sequencer.
// Counts CLK_DIV clock cycles per quarter and steps a 2-bit phase Q0..Q3.
// Ports:
//   CLK, RESET : clock and synchronous active-high reset
//   EN         : advance the counter this cycle (low freezes count and phase)
//   CLR        : restart at the first cycle of Q0 (wins over EN)
//   QTICK      : high on the last cycle of the current quarter while EN is high
//   PHASE      : current quarter, 0..3
module i2c_qdiv #(
   parameter int CLK_DIV = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       EN,
   input  logic       CLR,
   output logic       QTICK,
   output logic [1:0] PHASE
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    phase_q, phase_d;

   // Next count and phase. The tick is suppressed on a clear so the sequencer
   // never sees a quarter ending on a cycle that restarts the quarter.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      QTICK   = EN & ~CLR & (cnt_q == LAST);
      if (CLR) begin
         cnt_d   = '0;
         phase_d = 2'd0;
      end else if (EN) begin
         if (cnt_q == LAST) begin
            cnt_d   = '0;
            phase_d = phase_q + 2'd1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Counter and phase registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_q   <= '0;
         phase_q <= 2'd0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign PHASE = phase_q;

endmodule

// File: rtl/i2c_master_seq.sv
// Byte-level I2C master sequencer.
// Runs one complete transaction per accepted START: start condition, address
// byte with R/W bit, up to MAX_BYTES data bytes with ACK slots, stop condition.
// Ports:
//   CLK, RESET          : clock and synchronous active-high reset
//   ENB                 : global enable, low freezes all state and outputs
//   START, RW, ADDR     : transaction request, direction and 7-bit address
//   NBYTES              : data byte count, clamped to MAX_BYTES
//   WDATA/WVALID/WREADY : write byte handshake, one per written byte
//   RDATA/RVALID        : read byte and its one-cycle strobe
//   BUSY, DONE, NACK    : in progress, end-of-transaction pulse, sticky NACK
//   SCL, SDA_OE, SDA_IN : push-pull clock, SDA pull-low enable, sampled SDA
module i2c_master_seq
   import i2c_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int MAX_BYTES = 4,
   parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ENB,
   input  logic             START,
   input  logic             RW,
   input  logic [6:0]       ADDR,
   input  logic [CNT_W-1:0] NBYTES,
   input  logic [7:0]       WDATA,
   input  logic             WVALID,
   output logic             WREADY,
   output logic [7:0]       RDATA,
   output logic             RVALID,
   output logic             BUSY,
   output logic             DONE,
   output logic             NACK,
   output logic             SCL,
   output logic             SDA_OE,
   input  logic             SDA_IN
);

   state_e           state_q, state_d;
   logic [7:0]       sh_q, sh_d;
   logic [2:0]       bit_q, bit_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             rw_q, rw_d;
   logic             ack_q, ack_d;
   logic             loaded_q, loaded_d;
   logic             rvalid_q, rvalid_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             nack_q, nack_d;

   logic             qtick;
   logic [1:0]       phase_raw;
   phase_e           phase;
   logic             sample, bit_end, wready, load, div_en, div_clr;
   logic [CNT_W-1:0] nbytes_clamp;

   // Handshake and divider control. While the first write bit waits for data
   // the divider is frozen in Q0, so SCL stays low; the accepting cycle
   // restarts Q0 so the new SDA value appears at the start of a quarter.
   always_comb begin
      phase        = phase_e'(phase_raw);
      sample       = qtick & (phase == PH_Q1);
      bit_end      = qtick & (phase == PH_Q3);
      wready       = (state_q == S_WR_BYTE) & (bit_q == 3'd7) & ~loaded_q & (phase == PH_Q0);
      load         = ENB & wready & WVALID;
      div_en       = ENB & ~(wready & ~WVALID);
      div_clr      = ENB & ((state_q == S_IDLE) | load);
      nbytes_clamp = (NBYTES > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : NBYTES;
   end

   i2c_qdiv #(
      .CLK_DIV (CLK_DIV)
   ) u_qdiv (
      .CLK   (CLK),
      .RESET (RESET),
      .EN    (div_en),
      .CLR   (div_clr),
      .QTICK (qtick),
      .PHASE (phase_raw)
   );

   // Next-state and datapath. Every change is qualified by a quarter tick, an
   // accepted START or an accepted write byte, all of which require ENB, so
   // holding ENB low freezes the whole sequencer. The address byte is loaded
   // into the shifter at acceptance so it is ready on the first ADDR quarter.
   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      bit_d    = bit_q;
      rem_d    = rem_q;
      rw_d     = rw_q;
      ack_d    = ack_q;
      loaded_d = loaded_q;
      rvalid_d = rvalid_q & ~ENB;
      rdata_d  = rdata_q;
      nack_d   = nack_q;
      case (state_q)
         S_IDLE: begin
            if (ENB & START) begin
               state_d = S_START;
               rw_d    = RW;
               sh_d    = {ADDR, RW};
               rem_d   = nbytes_clamp;
               nack_d  = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_ADDR;
               bit_d   = 3'd7;
            end
         end
         S_ADDR, S_WR_BYTE: begin
            if (load) begin
               sh_d     = WDATA;
               loaded_d = 1'b1;
            end
            if (bit_end) begin
               if (bit_q == 3'd0) begin
                  state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
               end else begin
                  bit_d = bit_q - 3'd1;
                  sh_d  = {sh_q[6:0], 1'b0};
               end
            end
         end
         S_ADDR_ACK, S_WR_ACK: begin
            if (sample) begin
               ack_d = SDA_IN;
            end
            if (bit_end) begin
               bit_d    = 3'd7;
               loaded_d = 1'b0;
               if (ack_q) begin
                  nack_d  = 1'b1;
                  state_d = S_STOP;
               end else if (state_q == S_WR_ACK) begin
                  rem_d   = rem_q - CNT_W'(1);
                  state_d = (rem_q == CNT_W'(1)) ? S_STOP : S_WR_BYTE;
               end else if (rem_q == '0) begin
                  state_d = S_STOP;
               end else begin
                  state_d = (rw_q == RW_READ) ? S_RD_BYTE : S_WR_BYTE;
               end
            end
         end
         S_RD_BYTE: begin
            if (sample) begin
               sh_d = {sh_q[6:0], SDA_IN};
            end
            if (bit_end) begin
               if (bit_q == 3'd0) begin
                  state_d  = S_RD_ACK;
                  rdata_d  = sh_q;
                  rvalid_d = 1'b1;
               end else begin
                  bit_d = bit_q - 3'd1;
               end
            end
         end
         S_RD_ACK: begin
            if (bit_end) begin
               rem_d   = rem_q - CNT_W'(1);
               bit_d   = 3'd7;
               state_d = (rem_q == CNT_W'(1)) ? S_STOP : S_RD_BYTE;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any transaction immediately.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         sh_q     <= '0;
         bit_q    <= '0;
         rem_q    <= '0;
         rw_q     <= RW_WRITE;
         ack_q    <= 1'b0;
         loaded_q <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         nack_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         bit_q    <= bit_d;
         rem_q    <= rem_d;
         rw_q     <= rw_d;
         ack_q    <= ack_d;
         loaded_q <= loaded_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         nack_q   <= nack_d;
      end
   end

   // Bus pins and status. SCL follows the quarter phase; SDA is driven only
   // from the shifter, the master ACK decision or the start/stop shapes.
   // The write shifter is not driven onto SDA until a byte has been loaded.
   always_comb begin
      SCL    = 1'b1;
      SDA_OE = 1'b0;
      case (state_q)
         S_IDLE: begin
            SCL    = 1'b1;
            SDA_OE = 1'b0;
         end
         S_START: begin
            SCL    = (phase != PH_Q3);
            SDA_OE = (phase == PH_Q2) | (phase == PH_Q3);
         end
         S_STOP: begin
            SCL    = (phase != PH_Q0);
            SDA_OE = (phase == PH_Q0) | (phase == PH_Q1);
         end
         default: begin
            SCL = (phase == PH_Q1) | (phase == PH_Q2);
            case (state_q)
               S_ADDR:    SDA_OE = ~sh_q[7];
               S_WR_BYTE: SDA_OE = loaded_q & ~sh_q[7];
               S_RD_ACK:  SDA_OE = (rem_q > CNT_W'(1));
               default:   SDA_OE = 1'b0;
            endcase
         end
      endcase
      WREADY = wready;
      BUSY   = (state_q != S_IDLE);
      DONE   = (state_q == S_STOP) & bit_end;
      RVALID = rvalid_q;
      RDATA  = rdata_q;
      NACK   = nack_q;
   end

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed testbench for i2c_master_seq with a behavioural bus slave.
// The slave watches SCL/SDA, logs every byte and ACK slot seen on the bus,
// ACKs or NACKs the address, ACKs written bytes and returns read data.
module tb_i2c_master_seq;
   import i2c_pkg::*;

   logic       CLK = 1'b0;
   logic       RESET, ENB, START, RW;
   logic [6:0] ADDR;
   logic [2:0] NBYTES;
   logic [7:0] WDATA;
   logic       WVALID;
   logic       WREADY, RVALID, BUSY, DONE, NACK, SCL, SDA_OE;
   logic [7:0] RDATA;
   logic       slvPull = 1'b0;
   logic       sdaLine;

   assign sdaLine = ~SDA_OE & ~slvPull;

   i2c_master_seq dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .ENB    (ENB),
      .START  (START),
      .RW     (RW),
      .ADDR   (ADDR),
      .NBYTES (NBYTES),
      .WDATA  (WDATA),
      .WVALID (WVALID),
      .WREADY (WREADY),
      .RDATA  (RDATA),
      .RVALID (RVALID),
      .BUSY   (BUSY),
      .DONE   (DONE),
      .NACK   (NACK),
      .SCL    (SCL),
      .SDA_OE (SDA_OE),
      .SDA_IN (sdaLine)
   );

   always #5 CLK = ~CLK;

   int         total = 0;
   int         bad = 0;
   logic [7:0] busBytes[$];
   int         ackLog[$];
   logic [7:0] rdLog[$];
   int         stopCnt = 0, doneCnt = 0, busyCnt = 0, hsCnt = 0;
   int         stallLeft = 0, stallSclHigh = 0, wIdx = 0;
   logic [7:0] wBytes[8];
   logic [7:0] rdBytes[4];
   int         rdNum = 0;
   logic       slvAckAddr = 1'b1;
   logic       prevScl = 1'b1, prevSda = 1'b1, rdMode = 1'b0;
   logic [7:0] shReg = 8'h00;
   int         bitCnt = 0, byteCnt = 0;

   // Counts one comparison and reports it if the observed value is wrong.
   task automatic checkOutput(input string tag, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, actual, actual, expected, expected);
      end
   endtask

   function automatic int byteAt(input int i);
      if (i < busBytes.size()) return int'(busBytes[i]);
      return -1;
   endfunction

   function automatic int ackAt(input int i);
      if (i < ackLog.size()) return ackLog[i];
      return -1;
   endfunction

   function automatic int rdAt(input int i);
      if (i < rdLog.size()) return int'(rdLog[i]);
      return -1;
   endfunction

   // Bus slave: start/stop detection, bit capture on SCL rise, and drive
   // changes on SCL fall so SDA only moves while the clock is low.
   always @(negedge CLK) begin
      logic sda;
      sda = sdaLine;
      if (SCL && prevScl && prevSda && !sda) begin
         bitCnt  = 0;
         byteCnt = 0;
         shReg   = 8'h00;
         rdMode  = 1'b0;
         slvPull = 1'b0;
      end else if (SCL && prevScl && !prevSda && sda) begin
         stopCnt++;
      end else if (SCL && !prevScl) begin
         if (bitCnt < 8) shReg = {shReg[6:0], sda};
         else ackLog.push_back(int'(sda));
         bitCnt++;
      end else if (!SCL && prevScl) begin
         if (bitCnt == 8) begin
            busBytes.push_back(shReg);
            if (byteCnt == 0) rdMode = shReg[0];
         end
         if (bitCnt == 9) begin
            bitCnt = 0;
            byteCnt++;
         end
         if (bitCnt == 8) slvPull = (byteCnt == 0) ? slvAckAddr : !rdMode;
         else if (rdMode && byteCnt >= 1 && byteCnt <= rdNum) slvPull = ~rdBytes[byteCnt-1][7-bitCnt];
         else slvPull = 1'b0;
      end
      prevScl = SCL;
      prevSda = sda;
   end

   // Write data source: offers the next byte when WREADY is seen (after an
   // optional stall) and retires it once WREADY drops with WVALID still high.
   always @(negedge CLK) begin
      if (WVALID && !WREADY) begin
         WVALID = 1'b0;
         wIdx++;
         hsCnt++;
      end else if (WREADY && !WVALID) begin
         if (stallLeft > 0) begin
            stallLeft--;
            if (SCL) stallSclHigh++;
         end else begin
            WVALID = 1'b1;
            WDATA  = wBytes[wIdx];
         end
      end
   end

   // Output monitors.
   always @(negedge CLK) begin
      if (RVALID) rdLog.push_back(RDATA);
      if (DONE) doneCnt++;
      if (BUSY) busyCnt++;
   end

   // Clears the logs and issues a one-cycle START request.
   task automatic applyStimulus(input logic rw, input logic [6:0] addr, input int n);
      busBytes.delete();
      ackLog.delete();
      rdLog.delete();
      stopCnt = 0;
      doneCnt = 0;
      busyCnt = 0;
      hsCnt   = 0;
      wIdx    = 0;
      @(negedge CLK);
      START  = 1'b1;
      RW     = rw;
      ADDR   = addr;
      NBYTES = 3'(n);
      @(negedge CLK);
      START  = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (!BUSY) break;
      end
      checkOutput({tag, " finished"}, int'(BUSY), 0);
      repeat (4) @(negedge CLK);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int s;
      int holdChanges;
      logic sclHold, oeHold;
      RESET = 1'b1; ENB = 1'b1; START = 1'b0; RW = 1'b0; ADDR = 7'h00;
      NBYTES = 3'd0; WDATA = 8'h00; WVALID = 1'b0;
      repeat (3) @(negedge CLK);
      checkOutput("rst SCL", int'(SCL), 1);
      checkOutput("rst SDA_OE", int'(SDA_OE), 0);
      checkOutput("rst BUSY", int'(BUSY), 0);
      checkOutput("rst DONE", int'(DONE), 0);
      checkOutput("rst RVALID", int'(RVALID), 0);
      checkOutput("rst WREADY", int'(WREADY), 0);
      checkOutput("rst NACK", int'(NACK), 0);
      checkOutput("rst RDATA", int'(RDATA), 0);
      RESET = 1'b0;
      repeat (2) @(negedge CLK);

      $display("[TB] write 3 bytes to 0x60");
      wBytes[0] = 8'h31; wBytes[1] = 8'h43; wBytes[2] = 8'hFF;
      applyStimulus(RW_WRITE, 7'h60, 3);
      waitDone("wr3", 3000);
      checkOutput("wr3 nbytes", busBytes.size(), 4);
      checkOutput("wr3 byte0", byteAt(0), 'hC0);
      checkOutput("wr3 byte1", byteAt(1), 'h31);
      checkOutput("wr3 byte2", byteAt(2), 'h43);
      checkOutput("wr3 byte3", byteAt(3), 'hFF);
      s = 0;
      foreach (ackLog[i]) s += ackLog[i];
      checkOutput("wr3 ack slots", ackLog.size(), 4);
      checkOutput("wr3 nacked slots", s, 0);
      checkOutput("wr3 handshakes", hsCnt, 3);
      checkOutput("wr3 done", doneCnt, 1);
      checkOutput("wr3 nack", int'(NACK), 0);
      checkOutput("wr3 stops", stopCnt, 1);
      checkOutput("wr3 busy cycles", busyCnt, 611);

      $display("[TB] address NACK at 0x50");
      slvAckAddr = 1'b0;
      applyStimulus(RW_WRITE, 7'h50, 2);
      waitDone("anack", 3000);
      checkOutput("anack nbytes", busBytes.size(), 1);
      checkOutput("anack byte0", byteAt(0), 'hA0);
      checkOutput("anack ack0", ackAt(0), 1);
      checkOutput("anack handshakes", hsCnt, 0);
      checkOutput("anack nack", int'(NACK), 1);
      checkOutput("anack done", doneCnt, 1);
      checkOutput("anack stops", stopCnt, 1);
      checkOutput("anack busy cycles", busyCnt, 176);
      slvAckAddr = 1'b1;

      $display("[TB] address-only probe");
      applyStimulus(RW_WRITE, 7'h22, 0);
      checkOutput("probe nack cleared", int'(NACK), 0);
      waitDone("probe", 3000);
      checkOutput("probe nbytes", busBytes.size(), 1);
      checkOutput("probe byte0", byteAt(0), 'h44);
      checkOutput("probe ack0", ackAt(0), 0);
      checkOutput("probe handshakes", hsCnt, 0);
      checkOutput("probe done", doneCnt, 1);
      checkOutput("probe busy cycles", busyCnt, 176);

      $display("[TB] clamped write count");
      wBytes[0] = 8'h01; wBytes[1] = 8'h80; wBytes[2] = 8'h7E; wBytes[3] = 8'hC3;
      applyStimulus(RW_WRITE, 7'h11, 6);
      waitDone("clamp", 4000);
      checkOutput("clamp nbytes", busBytes.size(), 5);
      checkOutput("clamp byte0", byteAt(0), 'h22);
      checkOutput("clamp byte4", byteAt(4), 'hC3);
      checkOutput("clamp handshakes", hsCnt, 4);
      checkOutput("clamp busy cycles", busyCnt, 756);

      $display("[TB] read 2 bytes from 0x60");
      rdBytes[0] = 8'hA9; rdBytes[1] = 8'h55; rdNum = 2;
      applyStimulus(RW_READ, 7'h60, 2);
      waitDone("rd2", 3000);
      checkOutput("rd2 byte0", byteAt(0), 'hC1);
      checkOutput("rd2 rvalid count", rdLog.size(), 2);
      checkOutput("rd2 rdata0", rdAt(0), 'hA9);
      checkOutput("rd2 rdata1", rdAt(1), 'h55);
      checkOutput("rd2 addr ack", ackAt(0), 0);
      checkOutput("rd2 master ack", ackAt(1), 0);
      checkOutput("rd2 master nack", ackAt(2), 1);
      checkOutput("rd2 done", doneCnt, 1);
      checkOutput("rd2 stops", stopCnt, 1);
      checkOutput("rd2 busy cycles", busyCnt, 464);
      rdNum = 0;

      $display("[TB] write with 50-cycle WVALID stall");
      wBytes[0] = 8'h96;
      stallLeft = 50; stallSclHigh = 0;
      applyStimulus(RW_WRITE, 7'h60, 1);
      waitDone("stall", 3000);
      checkOutput("stall cycles used", stallLeft, 0);
      checkOutput("stall SCL high", stallSclHigh, 0);
      checkOutput("stall byte1", byteAt(1), 'h96);
      checkOutput("stall handshakes", hsCnt, 1);
      checkOutput("stall busy cycles", busyCnt, 371);

      $display("[TB] reset during third address bit");
      applyStimulus(RW_WRITE, 7'h60, 1);
      repeat (48) @(negedge CLK);
      checkOutput("abort busy before", int'(BUSY), 1);
      RESET = 1'b1;
      @(negedge CLK);
      checkOutput("abort SCL", int'(SCL), 1);
      checkOutput("abort SDA_OE", int'(SDA_OE), 0);
      checkOutput("abort BUSY", int'(BUSY), 0);
      checkOutput("abort done", doneCnt, 0);
      checkOutput("abort stops", stopCnt, 0);
      RESET = 1'b0;
      repeat (5) @(negedge CLK);

      $display("[TB] full write after reset, with ENB hold");
      wBytes[0] = 8'h5A;
      applyStimulus(RW_WRITE, 7'h60, 1);
      repeat (30) @(negedge CLK);
      sclHold = SCL; oeHold = SDA_OE; holdChanges = 0;
      ENB = 1'b0;
      repeat (10) begin
         @(negedge CLK);
         if (SCL !== sclHold || SDA_OE !== oeHold || BUSY !== 1'b1) holdChanges++;
      end
      ENB = 1'b1;
      waitDone("after", 3000);
      checkOutput("enb hold changes", holdChanges, 0);
      checkOutput("after byte0", byteAt(0), 'hC0);
      checkOutput("after byte1", byteAt(1), 'h5A);
      checkOutput("after done", doneCnt, 1);
      checkOutput("after nack", int'(NACK), 0);
      checkOutput("after busy cycles", busyCnt, 331);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
